// File: rtl/rf_wb_pkg.sv
// rf_wb_pkg: shared types and helpers for the register-file write-back scheduler.
//   DATA_W / ADDR_W / SEQ_W : default widths of a buffered write
//   wb_entry_t              : one buffered write {addr, data, seq}
//   seq_older(a, b)         : 1 when tag a is older than tag b (modular compare)
package rf_wb_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int SEQ_W  = 3;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [SEQ_W-1:0]  seq;
    } wb_entry_t;

    // Tags in flight never span more than half the tag space, so the MSB of
    // the modular difference tells which of the two was issued first.
    function automatic logic seq_older(input logic [SEQ_W-1:0] a,
                                       input logic [SEQ_W-1:0] b);
        logic [SEQ_W-1:0] diff;
        diff = a - b;
        return diff[SEQ_W-1];
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: DEPTH-entry register FIFO of wb_entry_t.
//   clk, rst : clock, asynchronous active-high reset
//   push/din : write one entry (caller guarantees not full)
//   pop      : drop the head entry (caller guarantees not empty)
//   head     : oldest entry, count : number of entries held
//   ents/vlds: every storage slot plus its valid bit, for the bypass scan
module wb_fifo
    import rf_wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  wb_entry_t                      din,
    input  logic                           pop,
    output wb_entry_t                      head,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output wb_entry_t [DEPTH-1:0]          ents,
    output logic [DEPTH-1:0]               vlds
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH+1);

    wb_entry_t [DEPTH-1:0] mem;
    logic [DEPTH-1:0]      vld;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      cnt;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem    <= '0;
            vld    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            // Push and pop never address the same slot: pop needs an entry,
            // push needs a free slot, so the two pointers differ whenever both fire.
            if (push) begin
                mem[wr_ptr] <= din;
                vld[wr_ptr] <= 1'b1;
                wr_ptr      <= ptr_next(wr_ptr);
            end
            if (pop) begin
                vld[rd_ptr] <= 1'b0;
                rd_ptr      <= ptr_next(rd_ptr);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign count = cnt;
    assign ents  = mem;
    assign vlds  = vld;

endmodule

// File: rtl/rf_wb_sched.sv
// rf_wb_sched: merges ALU (src0) and load (src1) write-backs into the single
// regfile write port in program order, with a two-port bypass over pending writes.
//   clk, rst                    : clock, asynchronous active-high reset
//   s0_valid/ready/addr/data    : ALU write-back request
//   s1_valid/ready/addr/data    : load write-back request
//   rf_write/rf_waddr/rf_wdata  : regfile write port, one write per cycle
//   byp_addr*/byp_hit*/byp_data*: decode-side lookup of newest pending value
//   pending                     : any write still buffered
// The entry struct takes its widths from rf_wb_pkg; overrides of DATA_W,
// ADDR_W or SEQ_W must match the package values.
module rf_wb_sched #(
    parameter int DATA_W = rf_wb_pkg::DATA_W,
    parameter int ADDR_W = rf_wb_pkg::ADDR_W,
    parameter int DEPTH  = 2,
    parameter int SEQ_W  = rf_wb_pkg::SEQ_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s0_valid,
    output logic              s0_ready,
    input  logic [ADDR_W-1:0] s0_addr,
    input  logic [DATA_W-1:0] s0_data,
    input  logic              s1_valid,
    output logic              s1_ready,
    input  logic [ADDR_W-1:0] s1_addr,
    input  logic [DATA_W-1:0] s1_data,
    output logic              rf_write,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic [ADDR_W-1:0] byp_addr0,
    input  logic [ADDR_W-1:0] byp_addr1,
    output logic              byp_hit0,
    output logic              byp_hit1,
    output logic [DATA_W-1:0] byp_data0,
    output logic [DATA_W-1:0] byp_data1,
    output logic              pending
);

    import rf_wb_pkg::*;

    localparam int CNT_W = $clog2(DEPTH+1);

    logic [SEQ_W-1:0] seq_q;
    logic             acc0, acc1;
    logic [SEQ_W-1:0] tag0, tag1;
    wb_entry_t        in0, in1;
    logic             pop0, pop1;
    wb_entry_t        head0, head1;
    logic [CNT_W-1:0] count0, count1;
    wb_entry_t [DEPTH-1:0] ents0, ents1;
    logic [DEPTH-1:0]      vlds0, vlds1;
    logic             ne0, ne1;

    assign s0_ready = (count0 < CNT_W'(DEPTH));
    assign s1_ready = (count1 < CNT_W'(DEPTH));
    assign acc0     = s0_valid && s0_ready;
    assign acc1     = s1_valid && s1_ready;

    // The load was issued before the ALU op retiring alongside it, so it takes
    // the lower tag when both arrive together.
    assign tag1 = seq_q;
    assign tag0 = (acc0 && acc1) ? seq_q + SEQ_W'(1) : seq_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) seq_q <= '0;
        else     seq_q <= seq_q + SEQ_W'(acc0) + SEQ_W'(acc1);
    end

    assign in0 = '{addr: s0_addr, data: s0_data, seq: tag0};
    assign in1 = '{addr: s1_addr, data: s1_data, seq: tag1};

    wb_fifo #(.DEPTH(DEPTH)) u_fifo0 (
        .clk(clk), .rst(rst), .push(acc0), .din(in0), .pop(pop0),
        .head(head0), .count(count0), .ents(ents0), .vlds(vlds0)
    );

    wb_fifo #(.DEPTH(DEPTH)) u_fifo1 (
        .clk(clk), .rst(rst), .push(acc1), .din(in1), .pop(pop1),
        .head(head1), .count(count1), .ents(ents1), .vlds(vlds1)
    );

    assign ne0     = (count0 != '0);
    assign ne1     = (count1 != '0);
    assign pending = ne0 || ne1;

    // Oldest head goes to the regfile and is popped on the same edge.
    always_comb begin
        pop0     = ne0 && (!ne1 || seq_older(head0.seq, head1.seq));
        pop1     = ne1 && !pop0;
        rf_write = ne0 || ne1;
        rf_waddr = '0;
        rf_wdata = '0;
        if (pop0) begin
            rf_waddr = head0.addr;
            rf_wdata = head0.data;
        end else if (pop1) begin
            rf_waddr = head1.addr;
            rf_wdata = head1.data;
        end
    end

    wb_entry_t [2*DEPTH-1:0] all_ents;
    logic [2*DEPTH-1:0]      all_vlds;

    assign all_ents = {ents1, ents0};
    assign all_vlds = {vlds1, vlds0};

    // Returns {hit, data}; data stays zero on a miss.
    function automatic logic [DATA_W:0] byp_scan(input logic [ADDR_W-1:0]     addr,
                                                 input wb_entry_t [2*DEPTH-1:0] ents,
                                                 input logic [2*DEPTH-1:0]      vlds);
        logic      hit;
        wb_entry_t best;
        hit  = 1'b0;
        best = '0;
        for (int i = 0; i < 2*DEPTH; i++) begin
            if (vlds[i] && ents[i].addr == addr &&
                (!hit || seq_older(best.seq, ents[i].seq))) begin
                hit  = 1'b1;
                best = ents[i];
            end
        end
        return {hit, best.data};
    endfunction

    assign {byp_hit0, byp_data0} = byp_scan(byp_addr0, all_ents, all_vlds);
    assign {byp_hit1, byp_data1} = byp_scan(byp_addr1, all_ents, all_vlds);

endmodule

// File: tb/tb_rf_wb_sched.sv
// tb_rf_wb_sched: table-driven vectors plus a program-order scoreboard for
// rf_wb_sched. Every accepted write is queued in acceptance order; each write
// the DUT presents must match the queue head.
module tb_rf_wb_sched;

    logic        clk;
    logic        rst;
    logic        s0_valid, s1_valid;
    logic        s0_ready, s1_ready;
    logic [4:0]  s0_addr, s1_addr;
    logic [31:0] s0_data, s1_data;
    logic        rf_write;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [4:0]  byp_addr0, byp_addr1;
    logic        byp_hit0, byp_hit1;
    logic [31:0] byp_data0, byp_data1;
    logic        pending;

    rf_wb_sched dut (
        .clk(clk), .rst(rst),
        .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_addr(s0_addr), .s0_data(s0_data),
        .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_addr(s1_addr), .s1_data(s1_data),
        .rf_write(rf_write), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .byp_addr0(byp_addr0), .byp_addr1(byp_addr1),
        .byp_hit0(byp_hit0), .byp_hit1(byp_hit1),
        .byp_data0(byp_data0), .byp_data1(byp_data1),
        .pending(pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        bit          src;
    } sb_t;

    typedef struct {
        bit v0; logic [4:0] a0; logic [31:0] d0;
        bit v1; logic [4:0] a1; logic [31:0] d1;
        logic [4:0] b0; logic [4:0] b1;
        bit ewr; logic [4:0] ewa; logic [31:0] ewd;
        bit eh0; logic [31:0] ed0;
        bit eh1; logic [31:0] ed1;
    } vec_t;

    sb_t  q[$];
    int   cnt0, cnt1;
    int   total, bad;
    vec_t vt[14];
    vec_t cur;
    bit   use_vec;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model_byp(input logic [4:0] a, output bit h, output logic [31:0] d);
        h = 1'b0;
        d = '0;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].addr == a) begin
                h = 1'b1;
                d = q[i].data;
                break;
            end
        end
    endfunction

    function automatic vec_t mk(bit v0, logic [4:0] a0, logic [31:0] d0,
                                bit v1, logic [4:0] a1, logic [31:0] d1,
                                logic [4:0] b0, logic [4:0] b1,
                                bit ewr, logic [4:0] ewa, logic [31:0] ewd,
                                bit eh0, logic [31:0] ed0, bit eh1, logic [31:0] ed1);
        vec_t v;
        v.v0 = v0; v.a0 = a0; v.d0 = d0; v.v1 = v1; v.a1 = a1; v.d1 = d1;
        v.b0 = b0; v.b1 = b1; v.ewr = ewr; v.ewa = ewa; v.ewd = ewd;
        v.eh0 = eh0; v.ed0 = ed0; v.eh1 = eh1; v.ed1 = ed1;
        return v;
    endfunction

    // One clock cycle: inputs are already driven; check at the falling edge,
    // update the scoreboard, then advance past the rising edge.
    task automatic step(output bit a0, output bit a1);
        bit          h;
        logic [31:0] d;
        sb_t         e;
        @(negedge clk);
        chk("s0_ready", s0_ready, cnt0 < 2);
        chk("s1_ready", s1_ready, cnt1 < 2);
        chk("pending", pending, q.size() != 0);
        chk("rf_write", rf_write, q.size() != 0);
        model_byp(byp_addr0, h, d);
        chk("byp_hit0", byp_hit0, h);
        chk("byp_data0", byp_data0, d);
        model_byp(byp_addr1, h, d);
        chk("byp_hit1", byp_hit1, h);
        chk("byp_data1", byp_data1, d);
        if (use_vec) begin
            chk("vec_write", rf_write, cur.ewr);
            if (cur.ewr) begin
                chk("vec_waddr", rf_waddr, cur.ewa);
                chk("vec_wdata", rf_wdata, cur.ewd);
            end
            chk("vec_hit0", byp_hit0, cur.eh0);
            chk("vec_data0", byp_data0, cur.ed0);
            chk("vec_hit1", byp_hit1, cur.eh1);
            chk("vec_data1", byp_data1, cur.ed1);
        end
        if (rf_write && q.size() != 0) begin
            e = q.pop_front();
            chk("sb_waddr", rf_waddr, e.addr);
            chk("sb_wdata", rf_wdata, e.data);
            if (e.src) cnt1--; else cnt0--;
        end
        a0 = s0_valid && s0_ready;
        a1 = s1_valid && s1_ready;
        if (a1) begin
            q.push_back('{addr: s1_addr, data: s1_data, src: 1'b1});
            cnt1++;
        end
        if (a0) begin
            q.push_back('{addr: s0_addr, data: s0_data, src: 1'b0});
            cnt0++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        s0_valid = 1'b0; s0_addr = '0; s0_data = '0;
        s1_valid = 1'b0; s1_addr = '0; s1_data = '0;
    endtask

    task automatic drain(input string nm);
        bit a0, a1;
        int n;
        idle_inputs();
        n = 0;
        while ((q.size() != 0 || pending) && n < 20) begin
            step(a0, a1);
            n++;
        end
        chk(nm, q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        bit a0, a1;
        bit saw_full0, saw_full1;
        int k0, k1, n, cyc;

        total = 0; bad = 0; cnt0 = 0; cnt1 = 0; use_vec = 0;
        rst = 1'b1;
        idle_inputs();
        byp_addr0 = 5'd3; byp_addr1 = 5'd7;

        vt[0]  = mk(1,3,32'h11, 0,0,0,     3,7,  0,0,0,       0,0,      0,0);
        vt[1]  = mk(0,0,0,      0,0,0,     3,7,  1,3,32'h11,  1,32'h11, 0,0);
        vt[2]  = mk(0,0,0,      0,0,0,     3,7,  0,0,0,       0,0,      0,0);
        vt[3]  = mk(1,5,32'hBB, 1,5,32'hAA, 5,7, 0,0,0,       0,0,      0,0);
        vt[4]  = mk(0,0,0,      0,0,0,     5,7,  1,5,32'hAA,  1,32'hBB, 0,0);
        vt[5]  = mk(0,0,0,      0,0,0,     5,7,  1,5,32'hBB,  1,32'hBB, 0,0);
        vt[6]  = mk(1,7,32'h5,  0,0,0,     5,7,  0,0,0,       0,0,      0,0);
        vt[7]  = mk(0,0,0,      0,0,0,     5,7,  1,7,32'h5,   0,0,      1,32'h5);
        vt[8]  = mk(0,0,0,      0,0,0,     5,7,  0,0,0,       0,0,      0,0);
        vt[9]  = mk(1,9,32'h01, 1,10,32'h10, 9,10, 0,0,0,     0,0,      0,0);
        vt[10] = mk(0,0,0,      1,9,32'h33,  9,10, 1,10,32'h10, 1,32'h01, 1,32'h10);
        vt[11] = mk(0,0,0,      0,0,0,     9,10, 1,9,32'h01,  1,32'h33, 0,0);
        vt[12] = mk(0,0,0,      0,0,0,     9,10, 1,9,32'h33,  1,32'h33, 0,0);
        vt[13] = mk(0,0,0,      0,0,0,     9,10, 0,0,0,       0,0,      0,0);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_write", rf_write, 0);
        chk("rst_waddr", rf_waddr, 0);
        chk("rst_wdata", rf_wdata, 0);
        chk("rst_s0_ready", s0_ready, 1);
        chk("rst_s1_ready", s1_ready, 1);
        chk("rst_pending", pending, 0);
        chk("rst_hit0", byp_hit0, 0);
        chk("rst_hit1", byp_hit1, 0);
        chk("rst_data0", byp_data0, 0);
        chk("rst_data1", byp_data1, 0);
        rst = 1'b0;

        // Directed table
        use_vec = 1;
        for (int i = 0; i < 14; i++) begin
            s0_valid = vt[i].v0; s0_addr = vt[i].a0; s0_data = vt[i].d0;
            s1_valid = vt[i].v1; s1_addr = vt[i].a1; s1_data = vt[i].d1;
            byp_addr0 = vt[i].b0; byp_addr1 = vt[i].b1;
            cur = vt[i];
            step(a0, a1);
        end
        use_vec = 0;
        idle_inputs();

        // Back-to-back on both sources until four of each are accepted
        k0 = 0; k1 = 0; cyc = 0; saw_full0 = 0; saw_full1 = 0;
        byp_addr0 = 5'd1; byp_addr1 = 5'd2;
        while ((k0 < 4 || k1 < 4) && cyc < 40) begin
            s0_valid = (k0 < 4); s0_addr = 5'(k0 + 1); s0_data = 32'h100 + k0;
            s1_valid = (k1 < 4); s1_addr = 5'(k1 + 1); s1_data = 32'h200 + k1;
            step(a0, a1);
            if (a0) k0++;
            if (a1) k1++;
            if (!s0_ready) saw_full0 = 1;
            if (!s1_ready) saw_full1 = 1;
            cyc++;
        end
        chk("fill_accept0", k0, 4);
        chk("fill_accept1", k1, 4);
        chk("fill_stall", saw_full0 | saw_full1, 1);
        drain("fill_drain");

        // Random interleaving across the tag wrap
        n = 0; cyc = 0;
        while (n < 20 && cyc < 200) begin
            s0_valid = 1'($urandom_range(0, 1));
            s1_valid = 1'($urandom_range(0, 1));
            s0_addr = 5'($urandom_range(0, 3)); s0_data = $urandom;
            s1_addr = 5'($urandom_range(0, 3)); s1_data = $urandom;
            byp_addr0 = 5'($urandom_range(0, 3));
            byp_addr1 = 5'($urandom_range(0, 3));
            step(a0, a1);
            n += int'(a0) + int'(a1);
            cyc++;
        end
        chk("wrap_count", n >= 20, 1);
        drain("wrap_drain");

        // Reset with three writes buffered
        s0_valid = 1; s0_addr = 5'd12; s0_data = 32'hC0;
        s1_valid = 1; s1_addr = 5'd13; s1_data = 32'hD0;
        byp_addr0 = 5'd12; byp_addr1 = 5'd13;
        step(a0, a1);
        s0_data = 32'hC1; s1_data = 32'hD1;
        step(a0, a1);
        idle_inputs();
        chk("pre_rst_pending", pending, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_write", rf_write, 0);
        chk("mid_rst_pending", pending, 0);
        chk("mid_rst_s0_ready", s0_ready, 1);
        chk("mid_rst_s1_ready", s1_ready, 1);
        chk("mid_rst_hit0", byp_hit0, 0);
        chk("mid_rst_hit1", byp_hit1, 0);
        q.delete();
        cnt0 = 0; cnt1 = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) step(a0, a1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rf_wb_sched.md
Name: rf_wb_sched

Overview:
- Write-back scheduler for the single write port of the 32x32 register file.
- Merges two write-back sources into one write stream in program order, and drains one write per cycle into the regfile write port (write/waddr1/din):
  - src0: ALU/execute result
  - src1: load data return from the LSU
- Buffers pending writes in per-source skid FIFOs.
- Provides a two-port bypass lookup so decode reads see pending (not yet written) values.

Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register address width
- DEPTH, 2, entries per source FIFO
- SEQ_W, 3, sequence tag width; must satisfy 2^(SEQ_W-1) >= 2*DEPTH

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- s0_valid  in  1  ALU write-back request
- s0_ready  out  1  src0 FIFO can accept
- s0_addr  in  ADDR_W  destination register
- s0_data  in  DATA_W  result
- s1_valid  in  1  load write-back request
- s1_ready  out  1  src1 FIFO can accept
- s1_addr  in  ADDR_W  destination register
- s1_data  in  DATA_W  load data
- rf_write  out  1  regfile write enable
- rf_waddr  out  ADDR_W  regfile write address
- rf_wdata  out  DATA_W  regfile write data
- byp_addr0, byp_addr1  in  ADDR_W  bypass lookup addresses (decode read ports)
- byp_hit0, byp_hit1  out  1  pending write to that address exists
- byp_data0, byp_data1  out  DATA_W  newest pending data for that address
- pending  out  1  any entry buffered (used for drain/serialise)

Behaviour:
- Reset (async, active-high):
  - Both FIFOs empty; sequence counter = 0.
  - rf_write = 0; rf_waddr and rf_wdata = 0.
  - s0_ready = s1_ready = 1; byp_hit* = 0; byp_data* = 0; pending = 0.
  - Reset mid-operation discards all buffered writes; no partial write is issued.
- Accept:
  - sN accepted on a rising edge where sN_valid && sN_ready.
  - The entry {addr, data, seq} is pushed into FIFO N.
- Ready:
  - sN_ready = (countN < DEPTH), from the registered count only; no pop-through into a full FIFO.
  - Push and pop on the same FIFO in one cycle are allowed when the FIFO is not full.
- Sequence tagging:
  - Global counter seq_q.
  - Only one source accepted: tag = seq_q, then seq_q += 1.
  - Both accepted in the same cycle: src1 (load, issued earlier) gets seq_q, src0 gets seq_q+1, then seq_q += 2.
  - Counter wraps modulo 2^SEQ_W.
- Scheduling:
  - Combinational, each cycle.
  - Only one FIFO non-empty: that FIFO's head is selected.
  - Both non-empty: the older head is selected. Age is decided by the MSB of (head0.seq - head1.seq) modulo 2^SEQ_W; MSB = 1 means head0 is older.
  - rf_write = 1 whenever any FIFO is non-empty; rf_waddr and rf_wdata come from the selected head.
  - The selected head is popped on the same clock edge the regfile captures it.
- Latency:
  - Entry accepted at edge N can be written at edge N+1 at the earliest.
  - Throughput: one write per cycle.
- Bypass:
  - Combinational over all valid entries in both FIFOs, including the head currently being written.
  - Hit on an address match; on multiple matches, the youngest seq wins (same modular compare).
  - No hit: byp_hit = 0 and byp_data = 0.
  - Bypass does not see same-cycle incoming sN_* data; the decode stage handles that forward path.
- Writes to r0 are buffered and written like any other register; the scheduler gives r0 no special treatment.
- pending = |(count0, count1).

Decomposition:
- Package rf_wb_pkg:
  - DATA_W/ADDR_W/SEQ_W defaults
  - wb_entry_t struct {addr, data, seq}
  - function seq_older(a, b) implementing the modular compare
- Sub-module wb_fifo:
  - DEPTH-entry register FIFO of wb_entry_t, with push/pop/count/head.
  - Exposes a flattened entry array plus per-entry valid bits for the bypass scan.
  - Instantiated twice.

Test Plan:
- Reset, then s0 writes {r3, 0x11} -> edge+1 rf_write=1, rf_waddr=3, rf_wdata=0x11; next cycle rf_write=0, pending=0.
- Same-cycle s1 {r5, 0xAA} and s0 {r5, 0xBB} -> rf writes r5=0xAA then r5=0xBB on consecutive cycles; byp_addr0=5 returns 0xBB while both are pending and 0xBB after the first drain.
- Hold s1_valid with no drain opportunity beyond DEPTH (back-to-back s0+s1 for 4 cycles) -> sN_ready drops to 0 exactly at count=2, no entry lost, and all 8 writes appear in tag order.
- Run 20 interleaved writes so seq wraps 7->0 -> write order stays age-correct across the wrap.
- Assert rst mid-burst with 3 entries pending -> rf_write=0 immediately, pending=0, s0_ready=s1_ready=1, no stale write after release.
- byp_addr1 = 7 with no pending r7 -> byp_hit1=0, byp_data1=0; after s0 {r7, 0x5} is accepted -> byp_hit1=1, byp_data1=0x5 until the write drains.
